// File: rtl/uart_rx16_if.sv
// Host-side register interface of the UART receiver: read strobe in,
// received byte and status flags out.
interface uart_rx16_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rdy;
    logic                 frm_err;
    logic                 ovr_err;
    logic                 busy;

    modport master (output rd, input rx_data, rx_rdy, frm_err, ovr_err, busy);
    modport slave  (input rd, output rx_data, rx_rdy, frm_err, ovr_err, busy);
endinterface

// File: rtl/uart_rx16.sv
// 8N1 UART receive engine driven by a 16x-oversample enable: mid-bit start
// validation, centre sampling, stop-bit check, sticky framing/overrun status.
module uart_rx16 #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_16x,
    input  logic        rxd,
    uart_rx16_if.slave  host
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxd_s;
    logic                 load;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load    = 1'b0;
        if (en_16x) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    tick_d = tick_q + 4'd1;
                    // tick 7 is the centre of the start bit: a glitch shorter than half a bit is rejected here
                    if (tick_q == 4'd7) begin
                        if (!rxd_s) begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == LAST_BIT) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        load    = 1'b1;
                        state_d = rxd_s ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    // a low stop bit holds here so a break is not mistaken for a new start
                    if (rxd_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host.rx_data <= '0;
            host.rx_rdy  <= 1'b0;
            host.frm_err <= 1'b0;
            host.ovr_err <= 1'b0;
        end else if (load) begin
            // a frame load beats a coincident read; the read still counts as having consumed the old byte
            host.rx_data <= shift_q;
            host.rx_rdy  <= 1'b1;
            host.frm_err <= ~rxd_s;
            host.ovr_err <= host.rx_rdy & ~host.rd;
        end else if (host.rd) begin
            host.rx_rdy  <= 1'b0;
            host.frm_err <= 1'b0;
            host.ovr_err <= 1'b0;
        end
    end

    assign host.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx16.sv
// Self-checking bench for uart_rx16: directed frames plus random traffic
// compared against a frame-level model of the host-visible registers.
module tb_uart_rx16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_16x = 1'b0;
    logic rxd = 1'b1;

    uart_rx16_if #(.DATA_BITS(DB)) bus();

    uart_rx16 #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_16x (en_16x),
        .rxd    (rxd),
        .host   (bus)
    );

    always #5 clk = ~clk;

    int unsigned div = 4;
    int unsigned ecnt = 0;
    always @(posedge clk) begin
        #1;
        if (ecnt + 1 >= div) begin
            ecnt = 0;
            en_16x = 1'b1;
        end else begin
            ecnt++;
            en_16x = 1'b0;
        end
    end

    logic [7:0] m_data = '0;
    bit m_rdy = 0, m_frm = 0, m_ovr = 0;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/data"}, 32'(bus.rx_data), 32'(m_data));
        chk({tag, "/rdy"},  32'(bus.rx_rdy),  32'(m_rdy));
        chk({tag, "/frm"},  32'(bus.frm_err), 32'(m_frm));
        chk({tag, "/ovr"},  32'(bus.ovr_err), 32'(m_ovr));
    endtask

    task automatic m_frame(input logic [7:0] b, input bit ok, input bit rd_same);
        m_ovr  = m_rdy && !rd_same;
        m_rdy  = 1;
        m_data = b;
        m_frm  = !ok;
    endtask

    task automatic m_clear();
        m_rdy = 0; m_frm = 0; m_ovr = 0;
    endtask

    task automatic tick_wait(input int n);
        repeat (n * int'(div)) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick_wait(16);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic host_read();
        bus.rd = 1'b1;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        m_clear();
    endtask

    task automatic frame(input logic [7:0] b, input bit ok, input int hold_low, input string tag);
        send(b, ok ? 1'b1 : 1'b0);
        if (!ok) tick_wait(hold_low);
        rxd = 1'b1;
        tick_wait(4);
        m_frame(b, ok, 0);
        check_all(tag);
        chk({tag, "/busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.rd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset/busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick_wait(4);

        // basic byte and read-back
        frame(8'hA5, 1, 0, "a5");
        host_read();
        check_all("a5_rd");

        // glitch of 3 ticks on the line
        rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fs/busy_hi", 32'(bus.busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (28) @(posedge clk);
        #1;
        chk("fs/busy_lo", 32'(bus.busy), 32'd0);
        tick_wait(160);
        check_all("fs");

        // framing error followed by a long break
        send(8'h3C, 1'b0);
        tick_wait(40);
        chk("brk/busy_hi", 32'(bus.busy), 32'd1);
        m_frame(8'h3C, 0, 0);
        check_all("brk");
        rxd = 1'b1;
        tick_wait(4);
        chk("brk/busy_lo", 32'(bus.busy), 32'd0);
        check_all("brk_after");
        host_read();

        // overrun
        frame(8'h11, 1, 0, "o11");
        frame(8'h22, 1, 0, "o22");
        host_read();
        check_all("ovr_rd");

        // read coincident with the frame load, en_16x held high
        div = 1;
        tick_wait(4);
        frame(8'h44, 1, 0, "c44");
        fork
            send(8'h55, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                bus.rd = 1'b1;
                @(posedge clk);
                #1;
                bus.rd = 1'b0;
            end
        join
        tick_wait(4);
        m_frame(8'h55, 1, 1);
        check_all("c55");

        // reset in the middle of data bit 4
        div = 4;
        tick_wait(4);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        tick_wait(8);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_data = '0;
        m_clear();
        check_all("mid_rst");
        chk("mid_rst/busy", 32'(bus.busy), 32'd0);
        tick_wait(64);
        frame(8'h0F, 1, 0, "f0f");

        // random traffic
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            bit ok;
            int hold;
            div = $urandom_range(4, 1);
            tick_wait(2);
            if ($urandom_range(1, 0) == 1) host_read();
            b    = 8'($urandom);
            ok   = ($urandom_range(7, 0) != 0);
            hold = ok ? 0 : int'($urandom_range(20, 0));
            frame(b, ok, hold, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx16.md
# uart_rx16

UART receive engine paired with the baud-rate generator: consumes its 16x-oversample enable pulse, deserialises an asynchronous 8N1 serial line, and presents received bytes to the host register interface. It performs mid-bit start validation, samples data at bit centres, checks the stop bit, and latches framing and overrun status until the host reads.

## Interface
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- SYNC_STAGES, 2, metastability flops on rxd (minimum 2).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_16x  in  1  one-clk pulse at 16x baud, from the baud generator; all bit timing advances only on cycles where it is high.
- rxd  in  1  asynchronous serial input; idle high.
- rd  in  1  host read strobe; clears rx_rdy, frm_err and ovr_err.
- rx_data  out  DATA_BITS  last received byte; holds until the next frame completes.
- rx_rdy  out  1  byte available.
- frm_err  out  1  stop bit of the last frame sampled low.
- ovr_err  out  1  a frame completed while rx_rdy was still set and unread.
- busy  out  1  high when state is not IDLE.

## Operation
- Sync chain: rxd passes through SYNC_STAGES flops; reset value 1. All decisions use the last stage (rxd_s).
- Counters: tick_cnt, 4 bits, wraps 15→0. bit_cnt counts 0..DATA_BITS-1. Shift register is DATA_BITS wide, shifts right, and inserts rxd_s at the MSB.
- Each state advances only on cycles with en_16x=1. On all other cycles, every state holds.
- States:
  - IDLE: when en_16x & rxd_s==0, go to START and clear tick_cnt.
  - START: increment tick_cnt each tick. When the tick arrives with tick_cnt==7 (mid-bit):
    - if rxd_s==0, go to DATA and clear tick_cnt and bit_cnt;
    - otherwise treat it as a false start and return to IDLE.
  - DATA: increment tick_cnt each tick. When tick_cnt==15, shift in rxd_s and increment bit_cnt. The sample taken with bit_cnt==DATA_BITS-1 moves the FSM to STOP.
  - STOP: when tick_cnt==15, sample the stop bit:
    - load rx_data from the shift register, set rx_rdy=1, and set frm_err=~rxd_s;
    - set ovr_err=1 if rx_rdy was already 1 and rd is low on this cycle;
    - if rxd_s==1, go to IDLE; if 0, go to BREAK.
  - BREAK: wait for rxd_s==1 (checked on en_16x), then go to IDLE. No new start is detected while the line stays low.
- Host side:
  - rd=1 clears rx_rdy, frm_err and ovr_err on the next edge.
  - If rd and a frame load happen on the same edge, the load wins: rx_rdy=1, frm_err is taken from the new frame, and ovr_err=0.
  - rd while rx_rdy=0 has no effect.
- Overrun policy: the new byte overwrites rx_data; the old byte is lost.
- Reset values:
  - rx_data=0, rx_rdy=0, frm_err=0, ovr_err=0, busy=0;
  - state IDLE, all counters 0, sync flops 1.
- Reset asserted mid-frame abandons the frame. No output change occurs other than returning to the reset values.

## Timing
- Input latency: SYNC_STAGES clk from an rxd edge to rxd_s.
- Start validation: the 8th en_16x tick after the falling edge is detected.
- Data sampling: each data bit is sampled 16 ticks after the previous sample, i.e. at bit centres.
- rx_rdy, rx_data and frm_err update on the edge of the en_16x cycle that samples the stop bit. They are visible the cycle after that pulse.
- Frame-complete latency: about 8 + 16·(DATA_BITS+1) ticks from the detected start edge to rx_rdy.
- busy:
  - rises the cycle after the start edge is detected;
  - falls the cycle after the STOP→IDLE or BREAK→IDLE transition.
- en_16x held high continuously is legal: one tick per clk.

## Test plan
- Send 0xA5 (8N1) with en_16x every 4 clk (bit = 64 clk) -> rx_data=0xA5, rx_rdy=1, frm_err=0, ovr_err=0; rd pulse -> rx_rdy=0 next cycle.
- Drive rxd low for 3 ticks, then high -> no rx_rdy; busy pulses then returns to 0; the FSM is back in IDLE before tick 9.
- Send 0x3C with the stop bit driven 0, then hold rxd low for 40 ticks -> rx_data=0x3C, frm_err=1, busy stays 1 until rxd returns high; no second frame is captured.
- Send 0x11 then 0x22 with no rd between -> rx_data=0x22, rx_rdy=1, ovr_err=1; rd -> all three flags clear.
- Assert rd on the exact cycle the 0x55 frame loads while rx_rdy=1 -> rx_rdy=1, ovr_err=0, rx_data=0x55.
- Assert rst during DATA bit 4 of 0xFF, release, then send 0x0F -> after reset all outputs are 0; 0x0F is received cleanly with frm_err=0.
